// File: rtl/led_presenter_if.sv
// Item/flash request handshake between a game controller and led_presenter.
// Ports: item_valid, item, speed, flash_req (master->slave); item_ready (slave->master).
interface led_presenter_if #(
  parameter int DATA_WIDTH = 4
);

  logic                  item_valid;
  logic [DATA_WIDTH-1:0] item;
  logic                  speed;
  logic                  flash_req;
  logic                  item_ready;

  modport master (
    output item_valid,
    output item,
    output speed,
    output flash_req,
    input  item_ready
  );

  modport slave (
    input  item_valid,
    input  item,
    input  speed,
    input  flash_req,
    output item_ready
  );

endinterface

// File: rtl/led_presenter.sv
// LED presenter: shows one item pattern for a timed on/gap window, or flashes all LEDs.
// Ports: clk, rst_n (async, active-low), bus (led_presenter_if.slave: item_valid,
//   item, speed, flash_req in; item_ready out), leds, busy, done (outputs).
// Build option: define LED_PRESENTER_FLASH_EN to include the all-LED flash sequence.
module led_presenter #(
  parameter int DATA_WIDTH = 4,
  parameter int T_ON_SLOW  = 8,
  parameter int T_ON_FAST  = 4,
  parameter int T_GAP      = 2,
  parameter int T_FLASH    = 4,
  parameter int N_FLASH    = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  led_presenter_if.slave        bus,
  output logic [DATA_WIDTH-1:0] leds,
  output logic                  busy,
  output logic                  done
);

  localparam int MAX_A = (T_ON_SLOW > T_ON_FAST) ? T_ON_SLOW : T_ON_FAST;
  localparam int MAX_B = (T_GAP > T_FLASH) ? T_GAP : T_FLASH;
  localparam int MAX_T = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW    = $clog2(MAX_T) + 1;

  localparam logic [CW-1:0] LD_SLOW = CW'(T_ON_SLOW - 1);
  localparam logic [CW-1:0] LD_FAST = CW'(T_ON_FAST - 1);
  localparam logic [CW-1:0] LD_GAP  = CW'(T_GAP - 1);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_SHOW = 3'd1;
  localparam logic [2:0] ST_GAP  = 3'd2;
  localparam logic [2:0] ST_DONE = 3'd5;

  if (T_ON_SLOW < 1 || T_ON_FAST < 1 || T_GAP < 1 ||
      T_FLASH < 1 || N_FLASH < 1) begin : g_bad_param
    $error("led_presenter: timing parameters must be nonzero");
  end

  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic          cnt_zero;
  logic          flash_go;
  logic          item_go;

  assign cnt_zero = (cnt == '0);

`ifdef LED_PRESENTER_FLASH_EN
  localparam int FW = $clog2(N_FLASH + 1);

  localparam logic [2:0]    ST_FON  = 3'd3;
  localparam logic [2:0]    ST_FOFF = 3'd4;
  localparam logic [CW-1:0] LD_FL   = CW'(T_FLASH - 1);
  localparam logic [FW-1:0] LAST_FL = FW'(N_FLASH - 1);

  logic [FW-1:0] fcnt;

  // Flash has priority; a simultaneous item is dropped.
  assign flash_go = bus.flash_req;
`else
  assign flash_go = 1'b0;
`endif

  assign item_go = bus.item_valid && !flash_go;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      leds  <= '0;
`ifdef LED_PRESENTER_FLASH_EN
      fcnt  <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          unique case (1'b1)
`ifdef LED_PRESENTER_FLASH_EN
            flash_go: begin
              state <= ST_FON;
              leds  <= '1;
              cnt   <= LD_FL;
              fcnt  <= '0;
            end
`endif
            item_go: begin
              // Speed only matters here: it picks the on-time load.
              state <= ST_SHOW;
              leds  <= bus.item;
              cnt   <= bus.speed ? LD_FAST : LD_SLOW;
            end
            default: begin
              leds <= '0;
            end
          endcase
        end

        ST_SHOW: begin
          if (cnt_zero) begin
            state <= ST_GAP;
            leds  <= '0;
            cnt   <= LD_GAP;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end

        ST_GAP: begin
          if (cnt_zero) begin
            state <= ST_DONE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end

`ifdef LED_PRESENTER_FLASH_EN
        ST_FON: begin
          if (cnt_zero) begin
            state <= ST_FOFF;
            leds  <= '0;
            cnt   <= LD_FL;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end

        ST_FOFF: begin
          if (!cnt_zero) begin
            cnt <= cnt - CW'(1);
          end else if (fcnt == LAST_FL) begin
            state <= ST_DONE;
            fcnt  <= '0;
          end else begin
            state <= ST_FON;
            leds  <= '1;
            cnt   <= LD_FL;
            fcnt  <= fcnt + FW'(1);
          end
        end
`endif

        ST_DONE: begin
          state <= ST_IDLE;
          leds  <= '0;
          cnt   <= '0;
        end

        default: begin
          state <= ST_IDLE;
          leds  <= '0;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Decoded straight from the state register so reset reaches them without a clock.
  assign bus.item_ready = (state == ST_IDLE);
  assign busy           = (state != ST_IDLE);
  assign done           = (state == ST_DONE);

endmodule

// File: doc/led_presenter.md
LED_PRESENTER -- requirements
Module: led_presenter

Interface
REQ-001 Parameter DATA_WIDTH, default 4, width of item and leds.
REQ-002 Parameter T_ON_SLOW, default 8, LED-on cycles per item when speed=0.
REQ-003 Parameter T_ON_FAST, default 4, LED-on cycles per item when speed=1.
REQ-004 Parameter T_GAP, default 2, LED-off cycles after each item.
REQ-005 Parameter T_FLASH, default 4, cycles per flash on-phase and per flash off-phase.
REQ-006 Parameter N_FLASH, default 3, flash on/off pairs per flash request.
REQ-007 clk  input  1  clock, rising edge.
REQ-008 rst_n  input  1  reset, asynchronous, active-low.
REQ-009 speed  input  1  0 = slow, 1 = fast; sampled on item acceptance.
REQ-010 item_valid  input  1  item offered.
REQ-011 item  input  DATA_WIDTH  LED pattern to show, normally one-hot.
REQ-012 item_ready  output  1  block idle, can accept item or flash request.
REQ-013 flash_req  input  1  request all-LED flash (victory/defeat).
REQ-014 leds  output  DATA_WIDTH  registered LED drive.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 done  output  1  one-cycle pulse when an item or flash sequence completes.

Function
REQ-017 States: IDLE, SHOW, GAP, FLASH_ON, FLASH_OFF, DONE; a single down-counter times every state, and a flash counter counts completed pairs.
REQ-018 IDLE: item_ready=1, leds=0, busy=0; in every other state item_ready=0.
REQ-019 Item accept: item_valid=1 in IDLE at edge k latches item and speed, enters SHOW; leds=latched item for exactly T_ON cycles (k+1 .. k+T_ON).
REQ-020 T_ON is T_ON_FAST when latched speed=1, else T_ON_SLOW; speed changes after acceptance have no effect.
REQ-021 SHOW expiry enters GAP: leds=0 for exactly T_GAP cycles, then DONE.
REQ-022 DONE lasts one cycle: done=1, leds=0; next state IDLE, so the next item can be accepted one cycle after done.
REQ-023 Item-to-item minimum period is T_ON+T_GAP+2 cycles.
REQ-024 flash_req=1 in IDLE enters FLASH_ON: leds all-ones for T_FLASH cycles, then FLASH_OFF with leds=0 for T_FLASH cycles, repeated N_FLASH times, then DONE.
REQ-025 flash_req and item_valid both high in IDLE: flash wins and the item is not accepted (item_ready is 0 from the next cycle on).
REQ-026 flash_req or item_valid outside IDLE: ignored, not queued.
REQ-027 item=0 is accepted and timed normally with leds=0; non-one-hot values are displayed unmodified.
REQ-028 Counter width: $clog2 of the largest timing parameter plus 1; parameters of 0 are illegal, and an assertion flags them in simulation.

Reset
REQ-029 rst_n low at any time, including mid-SHOW or mid-flash, asynchronously forces IDLE, leds=0, done=0, busy=0, item_ready=1, and clears all counters and latched item/speed.
REQ-030 After rst_n deasserts, the first rising edge may accept an item.

Configuration
REQ-031 Macro LED_PRESENTER_FLASH_EN defined: the flash function of REQ-024/025 is present.
REQ-032 Macro LED_PRESENTER_FLASH_EN undefined: FLASH_ON/FLASH_OFF states are absent and flash_req is ignored; item_valid is then accepted regardless of flash_req, and done pulses only for items.

Verification
REQ-033 Reset then item=4'b0010, speed=0 at cycle 0 -> leds=0010 for cycles 1-8, 0 for cycles 9-10, done=1 at cycle 11, item_ready=1 at cycle 12.
REQ-034 item=4'b1000, speed=1, speed toggled at cycle 2 -> leds=1000 for cycles 1-4 only, done at cycle 7.
REQ-035 flash_req with item_valid=1 in the same cycle (FLASH_EN) -> leds=1111/0000 alternating 4 cycles each, 3 times (cycles 1-24), done at cycle 25, item not consumed.
REQ-036 Back-to-back items, item_valid held high -> accepts at cycle 0 and cycle 12 (speed=0); item_ready low between them.
REQ-037 rst_n pulsed low at cycle 5 of SHOW -> leds=0 and busy=0 immediately (no clock edge needed), no done pulse.
REQ-038 Build without LED_PRESENTER_FLASH_EN, flash_req=1 alone -> no state change, leds stay 0, done never asserts.
